shared_port_arbiter: RTL
========================

SHARED_PORT_ARBITER -- requirements
Module: shared_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum beats accepted per grant before forced rotation (legal range 1..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req  input  8  per-requester request; req[i] high means requester i wants the shared port.
REQ-005 SHALL have port out_ready  input  1  the downstream stage accepts a beat this cycle.
REQ-006 SHALL have port gnt  output  8  registered one-hot grant, or all zero when no requester is granted.
REQ-007 SHALL have port sel  output  3  registered binary index of the granted requester; drives the select of the shared 8-to-1 datapath mux.
REQ-008 SHALL have port out_valid  output  1  the granted requester's beat is presented on the mux output.
REQ-009 SHALL have port beat_cnt  output  4  number of beats accepted in the current grant.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the port).
REQ-011 SHALL keep a 3-bit rotation pointer ptr; requester ptr has the highest priority, then ptr+1, and so on modulo 8.
REQ-012 In IDLE with req != 0, SHALL register a grant to the first set req bit at or after ptr, set sel to its index, and enter GRANT on the next edge: 1 cycle from request to grant.
REQ-013 In IDLE with req == 0, SHALL hold gnt = 0, hold sel at its previous value, and stay in IDLE.
REQ-014 SHALL drive out_valid = (state == GRANT) && req[sel], combinationally.
REQ-015 SHALL count an accepted beat when out_valid && out_ready, incrementing beat_cnt.
REQ-016 SHALL release the grant on the edge where req[sel] is low, or where a beat is accepted with beat_cnt == MAX_BURST-1.
REQ-017 On release, SHALL set ptr = sel+1 modulo 8, with 7 wrapping to 0.
REQ-018 On release, SHALL re-arbitrate in the same cycle from the new ptr over the current req: re-grant with no idle bubble if any req is set (the releasing requester included, at lowest priority), otherwise enter IDLE with gnt = 0.
REQ-019 SHALL clear beat_cnt to 0 on every release and on every new grant.
REQ-020 SHALL ignore req changes of non-granted requesters while in GRANT; no preemption.
REQ-021 With MAX_BURST = 1, SHALL rotate after every accepted beat.
REQ-022 SHALL keep gnt one-hot or zero, and keep gnt[sel] == 1 whenever in GRANT.
REQ-023 With out_ready held low, SHALL hold the grant indefinitely while req[sel] stays high.

Reset
REQ-024 On rst assertion, SHALL immediately and asynchronously force state = IDLE, gnt = 0, sel = 0, ptr = 0 and beat_cnt = 0; out_valid therefore reads 0.
REQ-025 On reset asserted mid-grant, SHALL drop the grant at once and discard any partial burst count.
REQ-026 After rst deasserts, SHALL arbitrate from ptr = 0, so requester 0 has the highest priority first.

Structure
REQ-027 SHALL place the state encoding (IDLE/GRANT), the requester count 8 and the select width 3 in the shared package mips_arb_pkg.
REQ-028 SHALL implement the combinational rotate-priority picker as sub-module rr_pick8 (req, ptr -> found, idx).
REQ-029 SHALL NOT instantiate the datapath mux; its sel output connects to the mux at the parent level.

Verification
REQ-030 Reset-out: rst high, then req = 8'hFF, rst released -> gnt = 8'h01, sel = 0 one cycle later; before that, all outputs 0.
REQ-031 Burst limit: req = 8'h05, out_ready = 1, MAX_BURST = 4 -> requester 0 receives 4 beats, then gnt = 8'h04 with no idle cycle, then requester 2 receives 4 beats, then back to requester 0.
REQ-032 Wrap-around: only req[7] and req[1] high, ptr = 7 -> grants 7, then 1, then 7; ptr wraps from 7 to 0.
REQ-033 Early release and stall: requester 3 granted, out_ready = 0 for 5 cycles then req[3] drops -> grant held 5 cycles with beat_cnt = 0, then IDLE with gnt = 0.
REQ-034 Sole requester: req = 8'h10 held, MAX_BURST = 2 -> re-granted to requester 4 after every 2 beats with no bubble; beat_cnt sequence 0,1,0,1.
REQ-035 Mid-burst reset: rst pulsed while requester 5 holds beat_cnt = 2 -> gnt = 0 immediately; after release, requester 0 wins if requesting.

Source files
------------

// File: rtl/mips_arb_pkg.sv
// Shared arbitration types: requester count, select width, FSM encoding.
// Latency: none (types and helpers only).
// Backpressure: n/a.
package mips_arb_pkg;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority picker: first set req bit at or after ptr, modulo 8.
// Latency: purely combinational.
// Backpressure: none; found is low when req is all zero.
module rr_pick8
  import mips_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit to ptr wins.
  always_comb begin
    found = |req;
    idx   = ptr;
    cand  = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SELW'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter for one shared port; bursts up to MAX_BURST beats per grant.
// Latency: 1 cycle request to grant; back-to-back re-grant on release, no bubble.
// Backpressure: out_ready low holds the grant and the beat count while req[sel] stays high.
module shared_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            out_valid,
  output logic [3:0]      beat_cnt
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  arb_state_t      state, state_d;
  logic [SELW-1:0] ptr, ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [SELW-1:0] sel_d;
  logic [3:0]      cnt_d;

  logic [SELW-1:0] pick_ptr;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic            accept;
  logic            rel;

  // The granted requester's beat is on the mux output while it keeps requesting.
  assign out_valid = (state == GRANT) && req[sel];
  assign accept    = out_valid && out_ready;

  // Release when the owner drops its request or its final allowed beat is taken.
  assign rel = (state == GRANT) &&
               (!req[sel] || (accept && (beat_cnt == LAST_BEAT)));

  // While granted, the picker already looks from sel+1 so a release can re-grant
  // in the same cycle; the owner itself lands at lowest priority.
  always_comb begin
    pick_ptr = ptr;
    if (state == GRANT) begin
      pick_ptr = sel + 3'd1;
    end
  end

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state: grant from IDLE, count beats, release and re-arbitrate.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    sel_d   = sel;
    ptr_d   = ptr;
    cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = sel + 3'd1;
          cnt_d = 4'd0;
          if (pick_found) begin
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (accept) begin
          cnt_d = beat_cnt + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State register; reset drops any grant and partial burst at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      sel      <= sel_d;
      ptr      <= ptr_d;
      beat_cnt <= cnt_d;
    end
  end

endmodule
